// File: rtl/user_io_host_pkg.sv
// Shared constants, FSM state type and channel helpers for the user_io SPI host.
package user_io_host_pkg;

   localparam logic [7:0] CMD_BUTTONS = 8'h01;
   localparam logic [7:0] CMD_JOY0    = 8'h02;
   localparam logic [7:0] CMD_JOY1    = 8'h03;
   localparam int         FRAME_BITS  = 16;

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

   function automatic logic [7:0] chan_cmd(input logic [1:0] ch);
      case (ch)
         2'd0:    return CMD_BUTTONS;
         2'd1:    return CMD_JOY0;
         default: return CMD_JOY1;
      endcase
   endfunction

   function automatic logic [1:0] next_chan(input logic [1:0] ch);
      return (ch == 2'd2) ? 2'd0 : ch + 2'd1;
   endfunction

endpackage

// File: rtl/user_io_host_if.sv
// SPI link between the IO-controller host and a user_io slave.
interface user_io_host_if;
   logic spi_sck;
   logic spi_ss_n;
   logic spi_mosi;
   logic spi_miso;

   modport master (output spi_sck, output spi_ss_n, output spi_mosi, input spi_miso);
   modport slave  (input spi_sck, input spi_ss_n, input spi_mosi, output spi_miso);
endinterface

// File: rtl/spi_frame_master.sv
// Mode-0 SPI engine: sends one 16-bit frame MSB first and returns the first received byte.
module spi_frame_master
   import user_io_host_pkg::*;
#(
   parameter int CLK_DIV = 4,
   parameter int SS_GAP  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [FRAME_BITS-1:0] tx_frame,
   output logic                  ready,
   output logic                  busy,
   output logic                  done,
   output logic                  rx_strobe,
   output logic [7:0]            rx_byte,
   user_io_host_if.master        spi
);

   localparam int CMAX = (CLK_DIV > SS_GAP) ? CLK_DIV : SS_GAP;
   localparam int CW   = $clog2(CMAX);
   localparam int BW   = $clog2(FRAME_BITS);
   localparam logic [CW-1:0] DIV_END = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] GAP_END = CW'(SS_GAP - 1);
   localparam logic [BW-1:0] BIT_END = BW'(FRAME_BITS - 1);
   localparam logic [BW-1:0] RX_LAST = BW'(7);

   state_t                  state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [BW-1:0]           bit_q, bit_d;
   logic                    sck_q, sck_d, ss_n_q, ss_n_d, mosi_q, mosi_d, done_q, done_d;
   logic [FRAME_BITS-2:0]   sh_q, sh_d;
   logic [6:0]              rx_q, rx_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         sck_q   <= 1'b0;
         ss_n_q  <= 1'b1;
         mosi_q  <= 1'b0;
         done_q  <= 1'b0;
         sh_q    <= '0;
         rx_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sck_q   <= sck_d;
         ss_n_q  <= ss_n_d;
         mosi_q  <= mosi_d;
         done_q  <= done_d;
         sh_q    <= sh_d;
         rx_q    <= rx_d;
      end
   end

   // MISO is sampled on the cycle SCK is driven high; MOSI only moves as SCK falls.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_d     = bit_q;
      sck_d     = sck_q;
      ss_n_d    = ss_n_q;
      mosi_d    = mosi_q;
      done_d    = 1'b0;
      sh_d      = sh_q;
      rx_d      = rx_q;
      rx_strobe = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SETUP;
               cnt_d   = '0;
               bit_d   = '0;
               ss_n_d  = 1'b0;
               mosi_d  = tx_frame[FRAME_BITS-1];
               sh_d    = tx_frame[FRAME_BITS-2:0];
            end
         end
         SETUP: begin
            if (cnt_q == DIV_END) begin
               state_d = SHIFT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         SHIFT: begin
            if (cnt_q != DIV_END) begin
               cnt_d = cnt_q + 1'b1;
            end else begin
               cnt_d = '0;
               sck_d = ~sck_q;
               if (!sck_q) begin
                  rx_d      = {rx_q[5:0], spi.spi_miso};
                  rx_strobe = (bit_q == RX_LAST);
               end else if (bit_q == BIT_END) begin
                  state_d = HOLD;
               end else begin
                  bit_d  = bit_q + 1'b1;
                  mosi_d = sh_q[FRAME_BITS-2];
                  sh_d   = {sh_q[FRAME_BITS-3:0], 1'b0};
               end
            end
         end
         HOLD: begin
            if (cnt_q == DIV_END) begin
               state_d = GAP;
               cnt_d   = '0;
               ss_n_d  = 1'b1;
               mosi_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         GAP: begin
            if (cnt_q == GAP_END) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign rx_byte      = {rx_q, spi.spi_miso};
   assign ready        = (state_q == IDLE);
   assign busy         = ~ss_n_q;
   assign done         = done_q;
   assign spi.spi_sck  = sck_q;
   assign spi.spi_ss_n = ss_n_q;
   assign spi.spi_mosi = mosi_q;

endmodule

// File: rtl/user_io_host.sv
// IO-controller end of the user_io link: resends buttons/joysticks on change and on refresh.
module user_io_host
   import user_io_host_pkg::*;
#(
   parameter int CLK_DIV = 4,
   parameter int REFRESH = 270000,
   parameter int SS_GAP  = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [7:0]     buttons_i,
   input  logic [7:0]     joystick_0_i,
   input  logic [7:0]     joystick_1_i,
   user_io_host_if.master spi,
   output logic [7:0]     core_type_o,
   output logic           core_type_valid_o,
   output logic           busy_o,
   output logic           frame_done_o
);

   localparam int RW = $clog2(REFRESH);
   localparam logic [RW-1:0] REF_END = RW'(REFRESH - 1);

   logic [2:0][7:0] inputs, shadow_q;
   logic [2:0]      pending_q;
   logic [1:0]      last_q, cur_q, sel, cand1, cand2;
   logic [7:0]      snap_q, rx_byte;
   logic [RW-1:0]   timer_q;
   logic            refresh_tick, ready, start, done, rx_strobe;

   assign inputs       = {joystick_1_i, joystick_0_i, buttons_i};
   assign refresh_tick = (timer_q == REF_END);

   // Round-robin: search the two channels after the last one sent, then the last one itself.
   always_comb begin
      cand1 = next_chan(last_q);
      cand2 = next_chan(cand1);
      sel   = last_q;
      if (pending_q[cand1]) begin
         sel = cand1;
      end else if (pending_q[cand2]) begin
         sel = cand2;
      end
   end

   assign start = ready && (|pending_q);

   spi_frame_master #(.CLK_DIV(CLK_DIV), .SS_GAP(SS_GAP)) u_frame (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .tx_frame  ({chan_cmd(sel), inputs[sel]}),
      .ready     (ready),
      .busy      (busy_o),
      .done      (done),
      .rx_strobe (rx_strobe),
      .rx_byte   (rx_byte),
      .spi       (spi)
   );

   assign frame_done_o = done;

   // Refresh beats a frame-end clear so a tick landing on HOLD's last cycle is not lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer_q           <= '0;
         pending_q         <= 3'b111;
         shadow_q          <= '0;
         last_q            <= 2'd2;
         cur_q             <= 2'd0;
         snap_q            <= '0;
         core_type_o       <= '0;
         core_type_valid_o <= 1'b0;
      end else begin
         timer_q <= refresh_tick ? '0 : timer_q + 1'b1;
         if (start) begin
            cur_q  <= sel;
            snap_q <= inputs[sel];
         end
         if (done) begin
            shadow_q[cur_q] <= snap_q;
            last_q          <= cur_q;
         end
         for (int ch = 0; ch < 3; ch++) begin
            if (refresh_tick) begin
               pending_q[ch] <= 1'b1;
            end else if (done && (cur_q == 2'(ch))) begin
               pending_q[ch] <= 1'b0;
            end else if ((inputs[ch] != shadow_q[ch]) && !(start && (sel == 2'(ch)))) begin
               pending_q[ch] <= 1'b1;
            end
         end
         if (rx_strobe) begin
            core_type_o       <= rx_byte;
            core_type_valid_o <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_user_io_host.sv
// Directed bench for user_io_host: slave monitor decodes frames, tasks check each scenario.
`timescale 1ns/1ps
module tb_user_io_host;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, rst_b_n;
   logic [7:0] buttons, joy0, joy1;
   logic [7:0] core_type, b_core_type;
   logic       core_valid, busy, frame_done;
   logic       b_core_valid, b_busy, b_frame_done;

   int checks = 0;
   int errors = 0;

   user_io_host_if a_if ();
   user_io_host_if b_if ();

   user_io_host dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .buttons_i         (buttons),
      .joystick_0_i      (joy0),
      .joystick_1_i      (joy1),
      .spi               (a_if),
      .core_type_o       (core_type),
      .core_type_valid_o (core_valid),
      .busy_o            (busy),
      .frame_done_o      (frame_done)
   );

   user_io_host #(.REFRESH(1000)) dut_b (
      .clk               (clk),
      .rst_n             (rst_b_n),
      .buttons_i         (8'h5A),
      .joystick_0_i      (8'h3C),
      .joystick_1_i      (8'h81),
      .spi               (b_if),
      .core_type_o       (b_core_type),
      .core_type_valid_o (b_core_valid),
      .busy_o            (b_busy),
      .frame_done_o      (b_frame_done)
   );

   assign b_if.spi_miso = 1'b0;

   // Slave model for bus A: decodes MOSI on SCK rise, returns 0xA4 on MISO during the command byte.
   logic [7:0]  slave_core = 8'hA4;
   logic [15:0] a_sh;
   int          a_bits = 0, a_low = 0, a_high = 0, a_gap_fall = 0, a_done_cnt = 0, miso_idx = 0;
   logic [15:0] a_frames[$];
   int          a_lows[$];
   int          a_gaps[$];

   always @(posedge clk) begin
      if (a_if.spi_ss_n === 1'b0) a_low++;
      else a_high++;
      if (frame_done === 1'b1) a_done_cnt++;
   end

   always @(negedge a_if.spi_ss_n) begin
      a_gap_fall = a_high;
      a_high     = 0;
      a_low      = 0;
      a_bits     = 0;
      miso_idx   = 0;
      a_if.spi_miso = slave_core[7];
   end

   always @(posedge a_if.spi_ss_n) begin
      if (a_bits == 16) begin
         a_frames.push_back(a_sh);
         a_lows.push_back(a_low);
         a_gaps.push_back(a_gap_fall);
      end
      a_high = 0;
   end

   always @(posedge a_if.spi_sck) begin
      a_sh = {a_sh[14:0], a_if.spi_mosi};
      a_bits++;
   end

   always @(negedge a_if.spi_sck) begin
      if (a_if.spi_ss_n === 1'b0) begin
         miso_idx++;
         a_if.spi_miso = (miso_idx < 8) ? slave_core[7-miso_idx] : 1'b0;
      end
   end

   // Monitor for bus B records each frame with the clk cycle on which SS fell.
   int          cyc = 0, b_bits = 0, b_start_fall = 0, b_done_cnt = 0;
   logic [15:0] b_sh;
   logic [15:0] b_frames[$];
   int          b_starts[$];

   always @(posedge clk) begin
      cyc++;
      if (b_frame_done === 1'b1) b_done_cnt++;
   end
   always @(negedge b_if.spi_ss_n) begin
      b_bits       = 0;
      b_start_fall = cyc;
   end
   always @(posedge b_if.spi_ss_n) begin
      if (b_bits == 16) begin
         b_frames.push_back(b_sh);
         b_starts.push_back(b_start_fall);
      end
   end
   always @(posedge b_if.spi_sck) begin
      b_sh = {b_sh[14:0], b_if.spi_mosi};
      b_bits++;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   function automatic logic [15:0] frame_at(input int i);
      if (i < a_frames.size()) return a_frames[i];
      return 16'hxxxx;
   endfunction

   function automatic int low_at(input int i);
      if (i < a_lows.size()) return a_lows[i];
      return -1;
   endfunction

   function automatic int gap_at(input int i);
      if (i < a_gaps.size()) return a_gaps[i];
      return -1;
   endfunction

   task automatic clear_logs();
      a_frames.delete();
      a_lows.delete();
      a_gaps.delete();
      a_done_cnt = 0;
   endtask

   task automatic wait_frames(input int n, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (a_frames.size() >= n) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_ss_fall(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (a_if.spi_ss_n === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_sck_rises(input int n, input int budget, output bit ok);
      logic prev;
      int   seen;
      ok   = 1'b0;
      seen = 0;
      prev = a_if.spi_sck;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (!prev && a_if.spi_sck === 1'b1) seen++;
         prev = a_if.spi_sck;
         if (seen == n) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n   = 1'b0;
      rst_b_n = 1'b0;
      buttons = 8'h00;
      joy0    = 8'h00;
      joy1    = 8'h00;
      a_if.spi_miso = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (a_if.spi_sck !== 1'b0) begin errors++; $display("[TB] FAIL reset_sck got %b want 0", a_if.spi_sck); end
      checks++; if (a_if.spi_ss_n !== 1'b1) begin errors++; $display("[TB] FAIL reset_ss_n got %b want 1", a_if.spi_ss_n); end
      checks++; if (a_if.spi_mosi !== 1'b0) begin errors++; $display("[TB] FAIL reset_mosi got %b want 0", a_if.spi_mosi); end
      checks++; if (core_type !== 8'h00) begin errors++; $display("[TB] FAIL reset_core_type got %h want 00", core_type); end
      checks++; if (core_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_core_valid got %b want 0", core_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
      checks++; if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_done got %b want 0", frame_done); end
      clear_logs();
      rst_n   = 1'b1;
      rst_b_n = 1'b1;
   endtask

   task automatic test_startup();
      logic [15:0] exp [3];
      bit ok;
      exp[0] = 16'h0100;
      exp[1] = 16'h0200;
      exp[2] = 16'h0300;
      wait_ss_fall(20, ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL startup_ss_fall timed out got 0 want 1"); end
      checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL startup_busy got %b want 1", busy); end
      wait_sck_rises(7, 200, ok);
      checks++; if (!ok || core_valid !== 1'b0) begin errors++; $display("[TB] FAIL core_valid_before_8th got %b ok=%0d want 0", core_valid, ok); end
      wait_sck_rises(1, 50, ok);
      checks++; if (!ok || core_type !== 8'hA4) begin errors++; $display("[TB] FAIL core_type got %h ok=%0d want a4", core_type, ok); end
      checks++; if (core_valid !== 1'b1) begin errors++; $display("[TB] FAIL core_valid_after_8th got %b want 1", core_valid); end
      wait_frames(3, 700, ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL startup_frames timed out got %0d want 3", a_frames.size()); end
      for (int i = 0; i < 3; i++) begin
         checks++; if (frame_at(i) !== exp[i]) begin errors++; $display("[TB] FAIL startup_frame%0d got %h want %h", i, frame_at(i), exp[i]); end
         checks++; if (low_at(i) != 136) begin errors++; $display("[TB] FAIL startup_ss_low%0d got %0d want 136", i, low_at(i)); end
         if (i > 0) begin
            checks++; if (gap_at(i) < 8) begin errors++; $display("[TB] FAIL startup_gap%0d got %0d want >=8", i, gap_at(i)); end
         end
      end
      repeat (60) @(negedge clk);
      checks++; if (a_frames.size() != 3) begin errors++; $display("[TB] FAIL startup_count got %0d want 3", a_frames.size()); end
      checks++; if (a_done_cnt != 3) begin errors++; $display("[TB] FAIL startup_done_pulses got %0d want 3", a_done_cnt); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL startup_idle_busy got %b want 0", busy); end
   endtask

   task automatic test_single_change();
      bit ok;
      clear_logs();
      joy0 = 8'h08;
      wait_frames(1, 300, ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL single_frame timed out got 0 want 1"); end
      repeat (400) @(negedge clk);
      checks++; if (a_frames.size() != 1) begin errors++; $display("[TB] FAIL single_count got %0d want 1", a_frames.size()); end
      checks++; if (frame_at(0) !== 16'h0208) begin errors++; $display("[TB] FAIL single_frame got %h want 0208", frame_at(0)); end
      checks++; if (low_at(0) != 136) begin errors++; $display("[TB] FAIL single_ss_low got %0d want 136", low_at(0)); end
      checks++; if (a_done_cnt != 1) begin errors++; $display("[TB] FAIL single_done_pulses got %0d want 1", a_done_cnt); end
   endtask

   task automatic test_back_to_back();
      bit ok;
      clear_logs();
      buttons = 8'h40;
      wait_frames(1, 300, ok);
      repeat (30) @(negedge clk);
      checks++; if (!ok || frame_at(0) !== 16'h0140) begin errors++; $display("[TB] FAIL b2b_lead_frame got %h want 0140", frame_at(0)); end
      clear_logs();
      buttons = 8'h21;
      joy0    = 8'h14;
      wait_frames(2, 500, ok);
      repeat (100) @(negedge clk);
      checks++; if (a_frames.size() != 2) begin errors++; $display("[TB] FAIL b2b_count got %0d want 2", a_frames.size()); end
      checks++; if (frame_at(0) !== 16'h0214) begin errors++; $display("[TB] FAIL b2b_first got %h want 0214", frame_at(0)); end
      checks++; if (frame_at(1) !== 16'h0121) begin errors++; $display("[TB] FAIL b2b_second got %h want 0121", frame_at(1)); end
      checks++; if (gap_at(1) < 8 || gap_at(1) > 12) begin errors++; $display("[TB] FAIL b2b_gap got %0d want 8..12", gap_at(1)); end
   endtask

   task automatic test_reset_mid_frame();
      logic [15:0] exp [4];
      bit ok;
      exp[0] = 16'h0177;
      exp[1] = 16'h0214;
      exp[2] = 16'h0300;
      exp[3] = 16'h0310;
      clear_logs();
      buttons = 8'h77;
      wait_ss_fall(20, ok);
      wait_sck_rises(9, 200, ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL abort_reach_bit9 timed out got 0 want 1"); end
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      checks++; if (a_if.spi_ss_n !== 1'b1) begin errors++; $display("[TB] FAIL abort_ss_n got %b want 1", a_if.spi_ss_n); end
      checks++; if (a_if.spi_sck !== 1'b0) begin errors++; $display("[TB] FAIL abort_sck got %b want 0", a_if.spi_sck); end
      checks++; if (core_valid !== 1'b0) begin errors++; $display("[TB] FAIL abort_core_valid got %b want 0", core_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy got %b want 0", busy); end
      repeat (3) @(negedge clk);
      clear_logs();
      rst_n = 1'b1;
      wait_frames(2, 400, ok);
      wait_ss_fall(40, ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL restart_frame3_start timed out got 0 want 1"); end
      repeat (40) @(negedge clk);
      joy1 = 8'h10;
      wait_frames(4, 500, ok);
      repeat (300) @(negedge clk);
      checks++; if (a_frames.size() != 4) begin errors++; $display("[TB] FAIL restart_count got %0d want 4", a_frames.size()); end
      for (int i = 0; i < 4; i++) begin
         checks++; if (frame_at(i) !== exp[i]) begin errors++; $display("[TB] FAIL restart_frame%0d got %h want %h", i, frame_at(i), exp[i]); end
      end
      checks++; if (gap_at(3) < 8 || gap_at(3) > 12) begin errors++; $display("[TB] FAIL midframe_resend_gap got %0d want 8..12", gap_at(3)); end
      checks++; if (core_valid !== 1'b1 || core_type !== 8'hA4) begin errors++; $display("[TB] FAIL restart_core got %b/%h want 1/a4", core_valid, core_type); end
      checks++; if (a_done_cnt != 4) begin errors++; $display("[TB] FAIL restart_done_pulses got %0d want 4", a_done_cnt); end
   endtask

   task automatic test_refresh();
      logic [7:0] vals [3];
      logic [15:0] want;
      vals[0] = 8'h5A;
      vals[1] = 8'h3C;
      vals[2] = 8'h81;
      for (int i = 0; i < 4000; i++) begin
         if (b_frames.size() >= 9) break;
         @(negedge clk);
      end
      checks++; if (b_frames.size() < 9) begin errors++; $display("[TB] FAIL refresh_count got %0d want >=9", b_frames.size()); end
      for (int i = 0; i < 9 && i < b_frames.size(); i++) begin
         want = {6'd0, 2'((i % 3) + 1), vals[i % 3]};
         checks++; if (b_frames[i] !== want) begin errors++; $display("[TB] FAIL refresh_frame%0d got %h want %h", i, b_frames[i], want); end
         if (i >= 3) begin
            checks++; if (b_starts[i] - b_starts[i-3] != 1000) begin errors++; $display("[TB] FAIL refresh_period%0d got %0d want 1000", i, b_starts[i] - b_starts[i-3]); end
         end
      end
      checks++; if (b_core_valid !== 1'b1 || b_core_type !== 8'h00) begin errors++; $display("[TB] FAIL refresh_core got %b/%h want 1/00", b_core_valid, b_core_type); end
      checks++; if (b_done_cnt != b_frames.size() + (b_busy ? 0 : 0)) begin errors++; $display("[TB] FAIL refresh_done_pulses got %0d want %0d", b_done_cnt, b_frames.size()); end
   endtask

   initial begin
      test_reset();
      test_startup();
      test_single_change();
      test_back_to_back();
      test_reset_mid_frame();
      test_refresh();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/user_io_host.md
Name: user_io_host

Overview:
- SPI master that plays the IO-controller end of the user_io link: it serialises button and joystick bytes onto SPI_SCK/SPI_SS_IO/SPI_MOSI so that a user_io slave decodes them exactly as it would from the board's ARM controller.
- Used on boards without the controller, and as the stimulus driver in core-level simulation of games such as pong.
- Sends a 2-byte frame, command then data, whenever an input changes and on a periodic refresh.
- Captures the core-type byte the slave returns on MISO during the command byte.

Parameters:
- CLK_DIV, 4: clk cycles per SCK half-period (>=2).
- REFRESH, 270000: clk cycles between forced resends of all channels (10 ms at 27 MHz).
- SS_GAP, 8: minimum clk cycles spi_ss_n stays high between frames.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- buttons_i  in  8  board buttons/switches, sent with cmd 0x01
- joystick_0_i  in  8  joystick 0 {.., fire[4], up[3], down[2], left[1], right[0]}, sent with cmd 0x02
- joystick_1_i  in  8  joystick 1, sent with cmd 0x03
- spi_sck  out  1  SPI clock, idles low
- spi_ss_n  out  1  slave select to SPI_SS_IO/CONF_DATA0, active low
- spi_mosi  out  1  data to the slave
- spi_miso  in  1  data from the slave
- core_type_o  out  8  last captured core-type byte
- core_type_valid_o  out  1  set after the first complete command byte; sticky
- busy_o  out  1  high while a frame is in progress (spi_ss_n low)
- frame_done_o  out  1  one-cycle pulse when spi_ss_n rises at frame end

Behaviour:
- Reset values: spi_sck=0, spi_ss_n=1, spi_mosi=0, core_type_o=0, core_type_valid_o=0, busy_o=0, frame_done_o=0. Shadow registers are 0, all three channels pending, refresh timer is 0.
- Reset asserted mid-frame forces spi_ss_n high immediately, asynchronously. The partial frame is discarded and never resumed.
- SPI mode 0, MSB first.
  - MOSI changes only while SCK is low; the slave samples on the SCK rising edge.
  - The master samples spi_miso on the clk cycle in which it drives SCK high.
- Frame = 16 bits: command byte {0x01 | 0x02 | 0x03}, then the data byte.
- FSM states and transitions:
  - IDLE -> SETUP when any channel is pending and the gap counter has expired. In the same cycle: snapshot the selected channel's input, drive spi_ss_n=0, present mosi=cmd[7], busy_o=1.
  - SETUP: hold CLK_DIV cycles -> SHIFT.
  - SHIFT: 16 bits, each bit is SCK low CLK_DIV cycles then high CLK_DIV cycles. The next bit is presented when SCK falls. After the 16th high phase -> HOLD with SCK=0.
  - HOLD: CLK_DIV cycles, then spi_ss_n=1, frame_done_o pulse, shadow[ch] <= snapshot, pending[ch] cleared -> GAP.
  - GAP: SS_GAP cycles -> IDLE.
- Frame timing at CLK_DIV=4: spi_ss_n low for exactly 4+128+4 = 136 clk cycles.
- Core-type capture: at the 8th rising SCK, core_type_o <= the 8 bits sampled MSB-first; core_type_valid_o <= 1.
- Pending rule:
  - pending[ch] sets when input_ch != shadow[ch], evaluated every cycle outside the channel's own snapshot cycle.
  - When the refresh timer reaches REFRESH-1, all three pending bits set and the timer wraps to 0. The timer runs continuously, including during frames.
- Selection: round-robin starting after the last channel sent, in order 0x01 -> 0x02 -> 0x03. After reset it starts at 0x01.
- Input change during that channel's frame: the snapshot is sent unchanged. Since the new value differs from the shadow, the channel is pending again after HOLD.
- Input change and refresh in the same cycle: pending is set once; no double send.
- Inputs are synchronous to clk; the block contains no synchroniser.

Decomposition:
- Package user_io_host_pkg holds:
  - CMD_BUTTONS=8'h01, CMD_JOY0=8'h02, CMD_JOY1=8'h03;
  - the FSM state enum {IDLE, SETUP, SHIFT, HOLD, GAP};
  - the frame length constant FRAME_BITS=16.
- Sub-module spi_frame_master: CLK_DIV SCK generator plus 16-bit shift/sample engine with start/done handshake and the rx byte output.
- The top level holds shadows, pending bits, refresh timer, round-robin arbiter and core-type latch.

Test Plan:
- Release reset with all inputs 0 and slave MISO returning 0xA4 -> three frames in order: MOSI 0x01 00, 0x02 00, 0x03 00. Each frame has spi_ss_n low 136 cycles and >=8 idle cycles between frames. core_type_o=0xA4 and core_type_valid_o=1 after the 8th SCK rise of frame 1.
- When idle, set joystick_0_i=0x08 -> exactly one frame, 0x02 08. The slave decodes joystick_0=0x08 and no other frame occurs before the refresh.
- Change joystick_1_i 0x00->0x10 in mid-frame of its own 0x03 frame -> that frame carries the old value, then an immediate second frame 0x03 10.
- Change buttons_i and joystick_0_i in the same cycle -> two back-to-back frames in round-robin order from the last channel sent, each carrying its value.
- REFRESH=1000 with static inputs -> all three channels resent every 1000 cycles, in round-robin order.
- Assert rst_n low at bit 9 of a frame -> spi_ss_n goes high asynchronously and spi_sck is 0. core_type_valid_o clears. After release, the full 3-frame startup sequence repeats.
